regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the single write port of the 32x64 register file between two writeback requesters: A is the ALU/address path and B is a multi-cycle unit such as memory load or multiplier. The block performs round-robin arbitration with a valid/ready handshake and registers the winner onto the port. It also filters writes to the zero register (X31) and keeps a saturating count of committed writes. It sits between the execute/memory writeback muxes and the register file's RW/BusW/RegWr inputs.

## Interface
- DATA_W, 64, writeback data width
- ADDR_W, 5, register address width
- ZERO_REG, 31, hardwired-zero register index; writes to it are discarded
- CNT_W, 16, width of the committed-write counter
- Clk  in  1  clock; all state updates on posedge
- ResetL  in  1  asynchronous, active-low reset
- ValidA  in  1  requester A has a write pending
- RWA  in  ADDR_W  requester A destination register
- BusWA  in  DATA_W  requester A write data
- ReadyA  out  1  A's request is accepted this cycle
- ValidB, RWB, BusWB, ReadyB  as for A, requester B
- Hold  in  1  suppresses all grants this cycle (debug/init owns the port)
- RW  out  ADDR_W  register file write address (registered)
- BusW  out  DATA_W  register file write data (registered)
- RegWr  out  1  register file write enable (registered)
- LastGrantB  out  1  round-robin pointer; 1 means B won most recently
- WrCount  out  CNT_W  committed writes, saturating

Clock and reset are fixed: one clock, Clk, and an asynchronous, active-low reset, ResetL.

## Operation
- Grant is combinational from Valid*, Hold and LastGrantB.
  - Hold=1: ReadyA=ReadyB=0.
  - Exactly one requester valid: that requester is granted.
  - Both valid: the requester that did not win last is granted. After reset (LastGrantB=0), B wins the first tie.
- A transfer occurs when Valid&Ready on a posedge. A requester must hold its Valid/RW/BusW stable until Ready. Ready never asserts without Valid.
- On each posedge:
  - Granted request: RW<=RWx, BusW<=BusWx, RegWr<=(RWx!=ZERO_REG).
  - No grant: RegWr<=0. RW and BusW hold their previous values.
- On a transfer to ZERO_REG: the request is still accepted (Ready=1), RegWr stays 0, and WrCount does not increment.
- LastGrantB updates only on a transfer: it is set to 1 when B transfers and to 0 when A transfers. A transfer to ZERO_REG still updates the pointer.
- WrCount increments on each posedge that loads RegWr=1. It saturates at all-ones and does not wrap.
- The output stage has no backpressure. The register file accepts every write, so one grant per cycle is sustained.

## Timing
- Reset (ResetL=0, asynchronous): RegWr=0, RW=0, BusW=0, LastGrantB=0, WrCount=0.
  - ReadyA and ReadyB are 0 while ResetL=0, regardless of Valid.
  - Reset deassertion is synchronous to the next posedge in the surrounding design.
- Latency: a request accepted at posedge k drives RegWr/RW/BusW from k through k+1. The register file captures it on the negedge between k and k+1, so data is readable after that negedge.
- Outputs are registered and glitch-free across the negedge write. RegWr is never high for more than one cycle per transfer.
- Fairness: with both Valid held high continuously, grants strictly alternate A,B,A,B... Each requester waits at most one cycle.
- Hold mid-stream: no transfer occurs, RegWr goes 0 the next cycle, and LastGrantB and WrCount are unchanged.
- Reset mid-operation: an in-flight registered write is dropped (RegWr forced 0 immediately). An accepted-but-uncommitted write is lost and requesters must reissue.

## Test plan
- Reset then single requester.
  - Stimulus: hold ResetL=0 with ValidA=1 and check ReadyA=0 and all outputs 0. Release reset, then drive ValidA=1, RWA=3, BusWA=0x1234.
  - Required: ReadyA=1 in that cycle; the next cycle shows RegWr=1, RW=3, BusW=0x1234; WrCount=1; LastGrantB=0.
- Tie after reset then alternation.
  - Stimulus: ValidA=ValidB=1 held for 4 cycles with distinct RWs 1 (A) and 2 (B).
  - Required: grant order B,A,B,A; RW sequence 2,1,2,1; WrCount=4.
- Zero-register filter.
  - Stimulus: ValidB=1, RWB=31, BusWB=0xFFFF.
  - Required: ReadyB=1; the next cycle RegWr=0; WrCount unchanged; LastGrantB=1.
- Hold.
  - Stimulus: both valid with Hold=1 for 3 cycles, then Hold=0.
  - Required: no Ready and RegWr=0 throughout the 3 cycles; on release, the tie goes to the requester opposite LastGrantB.
- Counter saturation.
  - Stimulus: CNT_W=4, then 20 consecutive valid A writes to register 5.
  - Required: WrCount=15 after the 15th commit and stays at 15.
- Async reset mid-write.
  - Stimulus: assert ResetL=0 between posedges while RegWr=1.
  - Required: RegWr falls without waiting for a clock edge; WrCount=0; RW=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file's single write port.
// Filters writes to the hardwired-zero register and counts committed writes.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              ResetL,
    input  logic              ValidA,
    input  logic [ADDR_W-1:0] RWA,
    input  logic [DATA_W-1:0] BusWA,
    output logic              ReadyA,
    input  logic              ValidB,
    input  logic [ADDR_W-1:0] RWB,
    input  logic [DATA_W-1:0] BusWB,
    output logic              ReadyB,
    input  logic              Hold,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    output logic              RegWr,
    output logic              LastGrantB,
    output logic [CNT_W-1:0]  WrCount
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    // Handshake: a transfer happens on a posedge where Valid and Ready are both
    // high; a requester holds Valid/RW/BusW stable until then, and Ready is
    // only ever raised for a requester whose Valid is high.

    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] sel_rw;
    logic [DATA_W-1:0] sel_bus_w;

    logic [ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0] bus_w_q, bus_w_d;
    logic              reg_wr_q, reg_wr_d;
    logic              last_grant_b_q, last_grant_b_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    always_comb begin
        grant_a        = 1'b0;
        grant_b        = 1'b0;
        sel_rw         = RWA;
        sel_bus_w      = BusWA;
        rw_d           = rw_q;
        bus_w_d        = bus_w_q;
        reg_wr_d       = 1'b0;
        last_grant_b_d = last_grant_b_q;
        wr_count_d     = wr_count_q;

        // Gating on ResetL keeps Ready low while reset is held.
        if (ResetL && !Hold) begin
            grant_a = ValidA && (!ValidB || last_grant_b_q);
            grant_b = ValidB && (!ValidA || !last_grant_b_q);
        end

        if (grant_b) begin
            sel_rw    = RWB;
            sel_bus_w = BusWB;
        end

        if (grant_a || grant_b) begin
            rw_d           = sel_rw;
            bus_w_d        = sel_bus_w;
            reg_wr_d       = (sel_rw != ZERO_ADDR);
            last_grant_b_d = grant_b;
        end

        if (reg_wr_d && (wr_count_q != {CNT_W{1'b1}})) begin
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            rw_q           <= '0;
            bus_w_q        <= '0;
            reg_wr_q       <= 1'b0;
            last_grant_b_q <= 1'b0;
            wr_count_q     <= '0;
        end else begin
            rw_q           <= rw_d;
            bus_w_q        <= bus_w_d;
            reg_wr_q       <= reg_wr_d;
            last_grant_b_q <= last_grant_b_d;
            wr_count_q     <= wr_count_d;
        end
    end

    assign ReadyA     = grant_a;
    assign ReadyB     = grant_b;
    assign RW         = rw_q;
    assign BusW       = bus_w_q;
    assign RegWr      = reg_wr_q;
    assign LastGrantB = last_grant_b_q;
    assign WrCount    = wr_count_q;

endmodule
